// File: rtl/add_job_sequencer_if.sv
// Handshake and adder bus bundle for add_job_sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface add_job_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;

  logic       add_start;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [8:0] add_sum;

  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;

  logic       busy;
  logic [7:0] job_count;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, out_ready,
    output in_ready, add_start, add_a, add_b, add_cin, out_valid, out_sum, busy, job_count
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, out_ready,
    input  in_ready, add_start, add_a, add_b, add_cin, out_valid, out_sum, busy, job_count
  );
endinterface

// File: rtl/add_job_sequencer.sv
// Buffers add jobs in a small FIFO and feeds them one at a time to an external
// multi-cycle serial adder, holding each result until downstream accepts it.
module add_job_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADD_CYCLES = 10
) (
  input logic                clk,
  input logic                rst,
  add_job_sequencer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CntW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(ADD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StCapture,
    StOut
  } state_e;

  state_e          state_q;
  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [OccW-1:0] occ_q;
  logic [CntW-1:0] wait_cnt_q;

  logic            add_start_q;
  logic [7:0]      add_a_q;
  logic [7:0]      add_b_q;
  logic            add_cin_q;
  logic            out_valid_q;
  logic [8:0]      out_sum_q;
  logic            busy_q;
  logic [7:0]      job_count_q;

  logic            in_ready;
  logic            push;
  logic            pop;
  logic [16:0]     head;

  // Ready comes from registered occupancy only, so a pop this cycle does not
  // make room for a push until the following cycle.
  assign in_ready = occ_q < OccFull;
  assign push     = bus.in_valid & in_ready;
  assign pop      = (state_q == StIdle) && (occ_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_cin, bus.in_b, bus.in_a};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        occ_q <= occ_q + OccW'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - OccW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      busy_q      <= 1'b0;
      job_count_q <= '0;
    end else begin
      add_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            {add_cin_q, add_b_q, add_a_q} <= head;
            add_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          wait_cnt_q <= CntLoad;
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            state_q <= StCapture;
          end else begin
            wait_cnt_q <= wait_cnt_q - CntW'(1);
          end
        end
        StCapture: begin
          out_sum_q   <= bus.add_sum;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            job_count_q <= job_count_q + 8'd1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.busy      = busy_q;
  assign bus.job_count = job_count_q;

  // Registered outputs must always agree with the state they decode.
  a_start_only_in_start: assert property (@(posedge clk) disable iff (rst)
    add_start_q |-> (state_q == StStart));
  a_out_valid_in_out: assert property (@(posedge clk) disable iff (rst)
    out_valid_q == (state_q == StOut));
  a_busy_not_idle: assert property (@(posedge clk) disable iff (rst)
    busy_q == (state_q != StIdle));
  a_occ_bounded: assert property (@(posedge clk) disable iff (rst)
    occ_q <= OccFull);
  a_ops_stable: assert property (@(posedge clk) disable iff (rst)
    !pop |=> $stable({add_cin_q, add_b_q, add_a_q}));

endmodule

// File: tb/tb_add_job_sequencer.sv
// Self-checking bench for add_job_sequencer: directed scenarios plus a randomized
// run scored against a queue-based model, with a behavioural serial adder.
module tb_add_job_sequencer;

  localparam int DEPTH = 4;
  localparam int N     = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_job_sequencer_if bus ();

  add_job_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .ADD_CYCLES(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];
  int n_acc;
  int n_done;

  localparam logic [37:0] RST_OUTS = {1'b1, 37'd0};

  function automatic logic [8:0] sum9(input logic [7:0] a, input logic [7:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  function automatic logic [37:0] outs();
    return {bus.in_ready, bus.add_start, bus.add_a, bus.add_b, bus.add_cin, bus.out_valid,
            bus.out_sum, bus.busy, bus.job_count};
  endfunction

  // Serial adder: result valid from ADD_CYCLES cycles after the start pulse,
  // the complement before that so an early capture shows up as a wrong sum.
  int unsigned add_age;
  logic [8:0]  add_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      add_age     <= 0;
      add_res     <= '0;
      bus.add_sum <= 9'h1AA;
    end else begin
      logic [8:0]  res_n;
      int unsigned age_n;
      res_n = add_res;
      age_n = add_age + 1;
      if (bus.add_start) begin
        res_n = sum9(bus.add_a, bus.add_b, bus.add_cin);
        age_n = 1;
      end
      add_res     <= res_n;
      add_age     <= age_n;
      bus.add_sum <= (age_n >= N) ? res_n : ~res_n;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      n_acc  <= 0;
      n_done <= 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(sum9(bus.in_a, bus.in_b, bus.in_cin));
        n_acc <= n_acc + 1;
      end
      if (bus.out_valid && bus.out_ready) n_done <= n_done + 1;
    end
  end

  task automatic push_job(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output bit ok);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      ok = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int limit);
    for (int t = 0; t < limit && !bus.out_valid; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", outs(), RST_OUTS);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_err++;
      $display("FAIL idle_after_release: got %h want %h", outs(), RST_OUTS);
    end
  endtask

  task automatic run_single(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic [8:0] exp_sum, input logic [7:0] exp_jc,
                            input string tag);
    int k, start_k, pulses, hold_err;
    start_k  = -1;
    pulses   = 0;
    hold_err = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = c;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_in_ready: got %b want 1", tag, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    while (k <= 4 * N && !bus.out_valid) begin
      if (bus.add_start) begin
        pulses++;
        if (start_k < 0) start_k = k;
      end
      if (start_k >= 0 && {bus.add_a, bus.add_b, bus.add_cin} !== {a, b, c}) hold_err++;
      @(negedge clk);
      k++;
    end
    if ({bus.add_a, bus.add_b, bus.add_cin} !== {a, b, c}) hold_err++;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_out_valid_timeout: got %b want 1", tag, bus.out_valid);
    end
    n_cmp++;
    if (start_k < 1 || start_k > 2) begin
      n_err++;
      $display("FAIL %s_start_cycle: got %0d want 1..2", tag, start_k);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL %s_start_pulses: got %0d want 1", tag, pulses);
    end
    n_cmp++;
    if (k - start_k != N + 2) begin
      n_err++;
      $display("FAIL %s_latency: got %0d want %0d", tag, k - start_k, N + 2);
    end
    n_cmp++;
    if (bus.out_sum !== exp_sum) begin
      n_err++;
      $display("FAIL %s_out_sum: got %h want %h", tag, bus.out_sum, exp_sum);
    end
    n_cmp++;
    if (hold_err != 0) begin
      n_err++;
      $display("FAIL %s_operand_hold: got %0d changes want 0", tag, hold_err);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.job_count !== exp_jc) begin
      n_err++;
      $display("FAIL %s_job_count: got %0d want %0d", tag, bus.job_count, exp_jc);
    end
    n_cmp++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      n_err++;
      $display("FAIL %s_back_to_idle: got %b want 00", tag, {bus.out_valid, bus.busy});
    end
    exp_q.delete();
  endtask

  task automatic test_single();
    run_single(8'h5A, 8'h3C, 1'b0, 9'h096, 8'd1, "single");
  endtask

  task automatic test_hold();
    run_single(8'hFF, 8'h01, 1'b1, 9'h101, 8'd2, "hold");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[6];
    logic [7:0] b[6];
    logic       c[6];
    int ready_err, refused, extra;
    for (int i = 0; i < 6; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
      c[i] = 1'($urandom);
    end
    bus.out_ready = 1'b0;
    ready_err = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = a[i];
      bus.in_b = b[i];
      bus.in_cin = c[i];
      if (!bus.in_ready) ready_err++;
      @(negedge clk);
    end
    n_cmp++;
    if (ready_err != 0) begin
      n_err++;
      $display("FAIL b2b_accept5: got %0d refusals want 0", ready_err);
    end
    bus.in_a = a[5];
    bus.in_b = b[5];
    bus.in_cin = c[5];
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_full: got in_ready %b want 0", bus.in_ready);
    end
    refused = 0;
    repeat (8) begin
      if (bus.in_ready) refused++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (refused != 0) begin
      n_err++;
      $display("FAIL b2b_sixth_refused: got %0d ready cycles want 0", refused);
    end
    bus.out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      wait_ov(4 * N);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== sum9(a[r], b[r], c[r])) begin
        n_err++;
        $display("FAIL b2b_result%0d: got valid %b sum %h want valid 1 sum %h", r,
                 bus.out_valid, bus.out_sum, sum9(a[r], b[r], c[r]));
      end
      @(negedge clk);
    end
    extra = 0;
    repeat (3 * N) begin
      if (bus.out_valid) extra++;
      @(negedge clk);
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL b2b_no_extra: got %0d extra results want 0", extra);
    end
    bus.out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_stall();
    logic [7:0] a[2];
    logic [7:0] b[2];
    logic       c[2];
    logic [8:0] s;
    bit ok0, ok1;
    int stab_err, start_err, seen;
    for (int i = 0; i < 2; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
      c[i] = 1'($urandom);
    end
    bus.out_ready = 1'b0;
    push_job(a[0], b[0], c[0], ok0);
    push_job(a[1], b[1], c[1], ok1);
    n_cmp++;
    if (!(ok0 && ok1)) begin
      n_err++;
      $display("FAIL stall_push: got %b%b want 11", ok0, ok1);
    end
    wait_ov(4 * N);
    s = bus.out_sum;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || s !== sum9(a[0], b[0], c[0])) begin
      n_err++;
      $display("FAIL stall_first: got valid %b sum %h want valid 1 sum %h", bus.out_valid, s,
               sum9(a[0], b[0], c[0]));
    end
    stab_err  = 0;
    start_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_sum !== s) stab_err++;
      if (bus.add_start) start_err++;
    end
    n_cmp++;
    if (stab_err != 0) begin
      n_err++;
      $display("FAIL stall_stable: got %0d unstable cycles want 0", stab_err);
    end
    n_cmp++;
    if (start_err != 0) begin
      n_err++;
      $display("FAIL stall_no_start: got %0d starts want 0", start_err);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    seen = -1;
    for (int k = 1; k <= 6; k++) begin
      if (bus.add_start && seen < 0) seen = k;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 2) begin
      n_err++;
      $display("FAIL stall_next_start: got cycle %0d want 2", seen);
    end
    wait_ov(4 * N);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== sum9(a[1], b[1], c[1])) begin
      n_err++;
      $display("FAIL stall_second: got valid %b sum %h want valid 1 sum %h", bus.out_valid,
               bus.out_sum, sum9(a[1], b[1], c[1]));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_push_pop();
    logic [7:0] a[6];
    logic [7:0] b[6];
    logic       c[6];
    bit ok;
    int push_fail;
    logic [3:0] rdy;
    for (int i = 0; i < 6; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
      c[i] = 1'($urandom);
    end
    bus.out_ready = 1'b0;
    push_fail = 0;
    for (int i = 0; i < 3; i++) begin
      push_job(a[i], b[i], c[i], ok);
      if (!ok) push_fail++;
    end
    wait_ov(4 * N);
    n_cmp++;
    if (push_fail != 0 || bus.out_valid !== 1'b1 || bus.out_sum !== sum9(a[0], b[0], c[0])) begin
      n_err++;
      $display("FAIL pp_first: got fails %0d valid %b sum %h want 0 1 %h", push_fail,
               bus.out_valid, bus.out_sum, sum9(a[0], b[0], c[0]));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL pp_idle: got busy %b want 0", bus.busy);
    end
    // Idle with two buffered: this push lands on the same edge as the pop.
    bus.in_valid = 1'b1;
    for (int i = 3; i < 6; i++) begin
      bus.in_a = a[i];
      bus.in_b = b[i];
      bus.in_cin = c[i];
      rdy[i-3] = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rdy[3] = bus.in_ready;
    n_cmp++;
    if (rdy !== 4'b0111) begin
      n_err++;
      $display("FAIL pp_occupancy: got ready seq %b want 0111", rdy);
    end
    bus.out_ready = 1'b1;
    for (int r = 1; r < 6; r++) begin
      wait_ov(4 * N);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== sum9(a[r], b[r], c[r])) begin
        n_err++;
        $display("FAIL pp_result%0d: got valid %b sum %h want valid 1 sum %h", r,
                 bus.out_valid, bus.out_sum, sum9(a[r], b[r], c[r]));
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int push_fail, got;
    logic [8:0] first;
    logic [7:0] na, nb;
    logic nc;
    bus.out_ready = 1'b0;
    push_fail = 0;
    for (int i = 0; i < 3; i++) begin
      push_job(8'($urandom), 8'($urandom), 1'($urandom), ok);
      if (!ok) push_fail++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (push_fail != 0 || {bus.busy, bus.add_start, bus.out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL rmid_in_wait: got fails %0d busy/start/valid %b want 0 100", push_fail,
               {bus.busy, bus.add_start, bus.out_valid});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_err++;
      $display("FAIL rmid_async: got %h want %h", outs(), RST_OUTS);
    end
    @(negedge clk);
    n_cmp++;
    if (outs() !== RST_OUTS) begin
      n_err++;
      $display("FAIL rmid_held: got %h want %h", outs(), RST_OUTS);
    end
    na = 8'($urandom);
    nb = 8'($urandom);
    nc = 1'($urandom);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = na;
    bus.in_b = nb;
    bus.in_cin = nc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    got = 0;
    first = '0;
    repeat (5 * N) begin
      if (bus.out_valid) begin
        if (got == 0) first = bus.out_sum;
        got++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_cmp++;
    if (got != 1 || first !== sum9(na, nb, nc)) begin
      n_err++;
      $display("FAIL rmid_after: got %0d results sum %h want 1 result sum %h", got, first,
               sum9(na, nb, nc));
    end
    n_cmp++;
    if (bus.job_count !== 8'd1) begin
      n_err++;
      $display("FAIL rmid_job_count: got %0d want 1", bus.job_count);
    end
    exp_q.delete();
  endtask

  task automatic test_random_wrap();
    int need, base_acc, starts, push_fail, t;
    bit ok;
    need      = 256 - n_done;
    base_acc  = n_acc;
    starts    = 0;
    push_fail = 0;
    fork
      begin
        for (int i = 0; i < need && push_fail == 0; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          push_job(8'($urandom), 8'($urandom), 1'($urandom), ok);
          if (!ok) push_fail++;
        end
      end
      begin
        t = 0;
        while (n_done < 256 && t < 20000 && push_fail == 0) begin
          @(negedge clk);
          t++;
          if (bus.add_start) starts++;
          n_cmp++;
          if (bus.in_ready !== ((n_acc - base_acc - starts) < DEPTH)) begin
            n_err++;
            $display("FAIL rnd_in_ready: got %b want %b", bus.in_ready,
                     (n_acc - base_acc - starts) < DEPTH);
          end
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0 || bus.out_sum !== exp_q[0] || bus.job_count !== 8'(n_done))
            begin
              n_err++;
              $display("FAIL rnd_result: got sum %h count %0d want sum %h count %0d",
                       bus.out_sum, bus.job_count, (exp_q.size() > 0) ? exp_q[0] : 9'h0,
                       8'(n_done));
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
      end
    join
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (n_done != 256 || push_fail != 0) begin
      n_err++;
      $display("FAIL rnd_completed: got %0d done %0d push fails want 256 0", n_done, push_fail);
    end
    n_cmp++;
    if (bus.job_count !== 8'd0) begin
      n_err++;
      $display("FAIL rnd_job_count_wrap: got %0d want 0", bus.job_count);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_leftover: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_stall();
    test_push_pop();
    test_reset_mid();
    test_random_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_job_sequencer.md
ADD_JOB_SEQUENCER -- requirements
Module: add_job_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: operand-job buffer entries (power of two, >=2).
REQ-002 Parameter ADD_CYCLES, default 10: clk cycles from add_start pulse to valid add_sum (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers a job.
REQ-006 in_ready  output  1  job buffer not full.
REQ-007 in_a, in_b  input  8 each  operands.
REQ-008 in_cin  input  1  carry-in for the job.
REQ-009 add_start  output  1  one-cycle start pulse to serial adder.
REQ-010 add_a, add_b  output  8 each  operands to adder, held stable for the whole job.
REQ-011 add_cin  output  1  initial carry to adder, held stable for the whole job.
REQ-012 add_sum  input  9  adder result bus.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_sum  output  9  captured result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 job_count  output  8  completed-job counter.

Function
REQ-018 Job accepted on a rising edge with in_valid & in_ready; {in_cin,in_b,in_a} written to FIFO tail.
REQ-019 in_ready = (occupancy < FIFO_DEPTH), combinational from registered occupancy; offers while full are ignored, not stored.
REQ-020 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH; simultaneous push and pop leaves occupancy unchanged, including when full (pop frees slot only next cycle, so push while full is refused).
REQ-021 FSM states: IDLE, START, WAIT, CAPTURE, OUT.
REQ-022 IDLE -> START when FIFO non-empty; head popped on that edge into add_a/add_b/add_cin registers.
REQ-023 START: add_start=1 for exactly this cycle; next state WAIT; wait counter loaded with ADD_CYCLES-1.
REQ-024 WAIT: counter decrements each cycle; at 0 -> CAPTURE.
REQ-025 CAPTURE: out_sum <= add_sum on this edge; -> OUT.
REQ-026 OUT: out_valid=1, out_sum stable; on out_ready=1 -> IDLE and job_count increments by 1 (wraps 255 -> 0); without out_ready stays in OUT indefinitely.
REQ-027 add_start asserted in no state other than START; add_a/add_b/add_cin change only on IDLE->START edge.
REQ-028 Latency: job accepted at edge T into empty FIFO with FSM idle -> START in cycle T+1..T+2, out_valid first high ADD_CYCLES+2 cycles after START cycle.
REQ-029 out_ready ignored outside OUT; in_valid accepted in every state while not full.
REQ-030 Results delivered in acceptance order; one job in flight at a time.

Reset
REQ-031 rst asserted (any time, including mid-job) immediately forces: state IDLE, FIFO empty, pointers 0, in_ready=1, add_start=0, add_a=add_b=0, add_cin=0, out_valid=0, out_sum=0, busy=0, job_count=0, wait counter 0.
REQ-032 In-flight and buffered jobs are discarded on reset; first edge after rst release with in_valid=1 accepts a job normally.

Verification
REQ-033 Single job a=8'h5A, b=8'h3C, cin=0, model adder returns 9'h096 -> add_start one pulse, out_valid ADD_CYCLES+2 cycles after it, out_sum=9'h096, job_count=1.
REQ-034 a=8'hFF, b=8'h01, cin=1 -> add_a/add_b/add_cin held FF/01/1 through WAIT; out_sum=9'h101.
REQ-035 Push 5 jobs back-to-back with out_ready=0, default depth -> in_ready low after 4 buffered plus 1 in flight; 6th offer refused; results emerge in order when out_ready=1.
REQ-036 out_ready held 0 for 20 cycles in OUT -> out_valid and out_sum stable, no new add_start; release -> next job starts.
REQ-037 rst pulsed during WAIT with 2 jobs buffered -> all outputs at reset values asynchronously, no result ever delivered for those jobs, job_count=0.
REQ-038 Simultaneous push and pop with occupancy 2 -> occupancy stays 2; 256 jobs completed -> job_count wraps to 0.
